// File: rtl/alu_pipe_if.sv
// Operand/result bus for alu_pipe.
//
// Handshake: each direction is a valid/ready pair. A word moves on a rising
// clock edge where valid and ready are both high. The producer keeps valid and
// its data stable until that edge; ready may depend combinationally on the
// consumer's state but never on valid of the same channel. Input channel:
// in_valid/in_ready with dato1/dato2/op_code. Output channel: out_valid/out_ready
// with salida and the flags.
interface alu_pipe_if #(
    parameter int NB_DATA = 8,
    parameter int NB_CODE = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [NB_DATA-1:0] dato1;
    logic [NB_DATA-1:0] dato2;
    logic [NB_CODE-1:0] op_code;
    logic               out_valid;
    logic               out_ready;
    logic [NB_DATA-1:0] salida;
    logic               flag_z;
    logic               flag_n;
    logic               flag_c;
    logic               flag_v;
    logic               flag_err;

    modport master (
        output in_valid, dato1, dato2, op_code, out_ready,
        input  in_ready, out_valid, salida, flag_z, flag_n, flag_c, flag_v, flag_err
    );

    modport slave (
        input  in_valid, dato1, dato2, op_code, out_ready,
        output in_ready, out_valid, salida, flag_z, flag_n, flag_c, flag_v, flag_err
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready back-pressure and a counter of
// results taken by the consumer. S1 holds the operands, S2 holds result+flags.
module alu_pipe #(
    parameter int NB_DATA  = 8,
    parameter int NB_CODE  = 6,
    parameter int NB_COUNT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_pipe_if.slave           bus,
    output logic [NB_COUNT-1:0] op_count
);
    localparam int MSB = NB_DATA - 1;
    localparam logic [NB_CODE-1:0] OP_ADD = NB_CODE'(6'b100000);
    localparam logic [NB_CODE-1:0] OP_SUB = NB_CODE'(6'b100010);
    localparam logic [NB_CODE-1:0] OP_AND = NB_CODE'(6'b100100);
    localparam logic [NB_CODE-1:0] OP_OR  = NB_CODE'(6'b100101);
    localparam logic [NB_CODE-1:0] OP_XOR = NB_CODE'(6'b100110);
    localparam logic [NB_CODE-1:0] OP_NOR = NB_CODE'(6'b100111);
    localparam logic [NB_CODE-1:0] OP_SRL = NB_CODE'(6'b000010);
    localparam logic [NB_CODE-1:0] OP_SRA = NB_CODE'(6'b000011);
    localparam logic [NB_CODE-1:0] OP_SLL = NB_CODE'(6'b000000);
    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

    // Stage 1: operand registers
    logic               s1_valid_q;
    logic [NB_DATA-1:0] a_q, b_q;
    logic [NB_CODE-1:0] code_q;

    // Stage 2: result registers
    logic               out_valid_q;
    logic [NB_DATA-1:0] salida_q;
    logic               z_q, n_q, c_q, v_q, err_q;
    logic [NB_COUNT-1:0] count_q;

    // Combinational next values
    logic [NB_DATA-1:0] salida_d;
    logic               z_d, n_d, c_d, v_d, err_d;
    logic [NB_DATA:0]   add_full, sub_full;
    logic               shift_big;
    logic               s1_en, s2_en;

    // S2 may load when empty or when its result leaves this cycle; S1 likewise
    // when empty or when it can hand its contents to S2.
    assign s2_en     = !out_valid_q || bus.out_ready;
    assign s1_en     = !s1_valid_q || s2_en;
    assign add_full  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full  = {1'b0, a_q} - {1'b0, b_q};
    assign shift_big = (b_q >= SHIFT_LIM);

    // S1: capture operands on an input transfer, drain when S2 takes them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            code_q     <= '0;
        end else if (s1_en) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                a_q    <= bus.dato1;
                b_q    <= bus.dato2;
                code_q <= bus.op_code;
            end
        end
    end

    // ALU: result and flags of the operation held in S1
    always_comb begin
        salida_d = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        err_d    = 1'b0;
        case (code_q)
            OP_ADD: begin
                salida_d = add_full[MSB:0];
                c_d      = add_full[NB_DATA];
                v_d      = (a_q[MSB] == b_q[MSB]) && (add_full[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                salida_d = sub_full[MSB:0];
                c_d      = sub_full[NB_DATA];
                v_d      = (a_q[MSB] != b_q[MSB]) && (sub_full[MSB] != a_q[MSB]);
            end
            OP_AND:  salida_d = a_q & b_q;
            OP_OR:   salida_d = a_q | b_q;
            OP_XOR:  salida_d = a_q ^ b_q;
            OP_NOR:  salida_d = ~(a_q | b_q);
            OP_SRL:  salida_d = shift_big ? '0 : (a_q >> b_q);
            OP_SRA:  salida_d = shift_big ? {NB_DATA{a_q[MSB]}}
                                          : NB_DATA'($signed(a_q) >>> b_q);
            OP_SLL:  salida_d = shift_big ? '0 : (a_q << b_q);
            default: err_d = 1'b1;
        endcase
        z_d = (salida_d == '0);
        n_d = salida_d[MSB];
    end

    // S2: register result when S1 advances; hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            salida_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                salida_q <= salida_d;
                z_q      <= z_d;
                n_q      <= n_d;
                c_q      <= c_d;
                v_q      <= v_d;
                err_q    <= err_d;
            end
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            count_q <= count_q + NB_COUNT'(1);
        end
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = out_valid_q;
    assign bus.salida    = salida_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_err  = err_q;
    assign op_count      = count_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors with literal expectations plus a
// reference model and scoreboard checked every cycle.
module tb_alu_pipe;
    localparam int NB_DATA  = 8;
    localparam int NB_CODE  = 6;
    localparam int NB_COUNT = 16;
    localparam int W        = NB_DATA + 5;   // {err,v,c,n,z,salida}

    localparam int ADD = 32, SUB = 34, AND_ = 36, OR_ = 37, XOR_ = 38, NOR_ = 39;
    localparam int SRL = 2, SRA = 3, SLL = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NB_COUNT-1:0] op_count;

    alu_pipe_if #(.NB_DATA(NB_DATA), .NB_CODE(NB_CODE)) bus ();

    alu_pipe #(.NB_DATA(NB_DATA), .NB_CODE(NB_CODE), .NB_COUNT(NB_COUNT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .op_count(op_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pure arithmetic on integers: operands as unsigned and as signed values.
    function automatic logic [W-1:0] model(input int op, input int a, input int b);
        int mask, half, sa, sb, res, s;
        logic err, v, c;
        logic [W-1:0] r;
        mask = (1 << NB_DATA) - 1;
        half = 1 << (NB_DATA - 1);
        sa = (a >= half) ? a - (1 << NB_DATA) : a;
        sb = (b >= half) ? b - (1 << NB_DATA) : b;
        err = 1'b0; v = 1'b0; c = 1'b0; res = 0;
        case (op)
            ADD: begin
                res = (a + b) & mask;
                c = ((a + b) > mask);
                s = sa + sb;
                v = (s > half - 1) || (s < -half);
            end
            SUB: begin
                res = (a - b) & mask;
                c = (a < b);
                s = sa - sb;
                v = (s > half - 1) || (s < -half);
            end
            AND_: res = a & b;
            OR_:  res = a | b;
            XOR_: res = a ^ b;
            NOR_: res = ~(a | b) & mask;
            SRL:  res = (b >= NB_DATA) ? 0 : (a >> b);
            SRA:  res = (b >= NB_DATA) ? ((a >= half) ? mask : 0) : ((sa >>> b) & mask);
            SLL:  res = (b >= NB_DATA) ? 0 : ((a << b) & mask);
            default: begin err = 1'b1; res = 0; end
        endcase
        r[NB_DATA-1:0] = res[NB_DATA-1:0];
        r[NB_DATA]     = (res == 0);
        r[NB_DATA+1]   = res[NB_DATA-1];
        r[NB_DATA+2]   = c;
        r[NB_DATA+3]   = v;
        r[NB_DATA+4]   = err;
        return r;
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {bus.flag_err, bus.flag_v, bus.flag_c, bus.flag_n, bus.flag_z, bus.salida};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [W-1:0]        exp_q[$];
    logic [NB_COUNT-1:0] exp_count = '0;
    logic                prev_stall = 1'b0;
    logic [W-1:0]        prev_out = '0;

    // Inputs change just after the rising edge, so at the falling edge both
    // the DUT outputs and the transfers about to happen are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_count  = '0;
            prev_stall = 1'b0;
        end else begin
            check("op_count", 32'(op_count), 32'(exp_count));
            if (prev_stall)
                check("stall_hold", 32'(dut_out()), 32'(prev_out));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("result", 32'(dut_out()), 32'(exp_q[0]));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        exp_count = exp_count + 1'b1;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = dut_out();
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(int'(bus.op_code), int'(bus.dato1), int'(bus.dato2)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int op, input int a, input int b);
        bus.in_valid = v;
        bus.op_code  = NB_CODE'(op);
        bus.dato1    = NB_DATA'(a);
        bus.dato2    = NB_DATA'(b);
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // One op into an idle, unstalled pipe; result must be there two cycles later.
    task automatic send_one(input string name, input int op, input int a, input int b,
                            input logic [NB_DATA-1:0] exp_s, input logic [4:0] exp_f);
        check({name, "_model"}, 32'(model(op, a, b)), 32'({exp_f, exp_s}));
        bus.out_ready = 1'b1;
        drive(1'b1, op, a, b);
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 0, 0, 0);
        tick();
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_salida"}, 32'(bus.salida), 32'(exp_s));
        check({name, "_flags"}, 32'({bus.flag_err, bus.flag_v, bus.flag_c, bus.flag_n, bus.flag_z}),
              32'(exp_f));
    endtask

    // ---------------- stimulus ----------------
    int so_op[4] = '{ADD, SUB, XOR_, SLL};
    int so_a[4]  = '{8'h01, 8'h05, 8'hAA, 8'h03};
    int so_b[4]  = '{8'h02, 8'h03, 8'h55, 8'h02};

    initial begin
        int idx;
        bus.out_ready = 1'b1;
        drive(1'b0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_salida", 32'(bus.salida), 32'd0);
        check("rst_flags", 32'({bus.flag_err, bus.flag_v, bus.flag_c, bus.flag_n, bus.flag_z}), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors, flags as {err,v,c,n,z}
        send_one("add_ovf",  ADD,  8'h7F, 8'h01, 8'h80, 5'b01010);
        send_one("sub_brw",  SUB,  8'h00, 8'h01, 8'hFF, 5'b00110);
        send_one("sub_ovf",  SUB,  8'h80, 8'h01, 8'h7F, 5'b01000);
        send_one("sra3",     SRA,  8'h80, 8'd3,  8'hF0, 5'b00010);
        send_one("srl3",     SRL,  8'h80, 8'd3,  8'h10, 5'b00000);
        send_one("sra9",     SRA,  8'h80, 8'd9,  8'hFF, 5'b00010);
        send_one("sll8",     SLL,  8'h81, 8'd8,  8'h00, 5'b00001);
        send_one("bad_op",   63,   8'h5A, 8'hA5, 8'h00, 5'b10001);
        send_one("add_cry",  ADD,  8'hFF, 8'h01, 8'h00, 5'b00101);
        send_one("and",      AND_, 8'hF0, 8'h3C, 8'h30, 5'b00000);
        send_one("or",       OR_,  8'h0F, 8'hF0, 8'hFF, 5'b00010);
        send_one("xor",      XOR_, 8'hFF, 8'h0F, 8'hF0, 5'b00010);
        send_one("nor",      NOR_, 8'h00, 8'h00, 8'hFF, 5'b00010);
        send_one("sll7",     SLL,  8'h01, 8'd7,  8'h80, 5'b00010);
        send_one("sra_pos",  SRA,  8'h40, 8'd2,  8'h10, 5'b00000);
        send_one("sra_max",  SRA,  8'h7F, 8'hFF, 8'h00, 5'b00001);
        tick();

        // Back-pressure: consumer stalls 6 cycles while 4 ops are offered
        do_reset();
        bus.out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(idx < 4, so_op[idx % 4], so_a[idx % 4], so_b[idx % 4]);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        check("stall_accepted", 32'(idx), 32'd2);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_salida", 32'(bus.salida), 32'h03);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            drive(1'b1, so_op[idx], so_a[idx], so_b[idx]);
            @(negedge clk);
            if (bus.in_ready) idx++;
            tick();
        end
        check("release_all_sent", 32'(idx), 32'd4);
        drive(1'b0, 0, 0, 0);
        for (int cyc = 0; cyc < 4; cyc++) tick();
        check("release_op_count", 32'(op_count), 32'd4);
        check("release_drained", 32'(bus.out_valid), 32'd0);

        // Full-rate streaming: in_ready must stay high while out_ready is high
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i % 2) ? ADD : SUB, 8'h10 * i, 8'h0F + i);
            @(negedge clk);
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        drive(1'b0, 0, 0, 0);

        // Mixed back-pressure with a fixed out_ready pattern
        for (int i = 0; i < 24; i++) begin
            logic [7:0] pat;
            pat = 8'b1011_0010;
            bus.out_ready = pat[i % 8];
            drive(1'b1, SRA, 8'h80 + i, i % 10);
            @(negedge clk);
            tick();
        end
        drive(1'b0, 0, 0, 0);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) tick();
        check("mixed_drained", 32'(bus.out_valid), 32'd0);

        // Reset with both stages full: nothing stale may come out afterwards
        bus.out_ready = 1'b0;
        drive(1'b1, ADD, 8'h11, 8'h22);
        tick();
        drive(1'b1, ADD, 8'h33, 8'h44);
        tick();
        drive(1'b0, 0, 0, 0);
        tick();
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        do_reset();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_op_count", 32'(op_count), 32'd0);
        check("midrst_salida", 32'(bus.salida), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end

        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
